vga_pixel_pipeline: RTL and testbench
=====================================

Name: vga_pixel_pipeline

Overview:
- Stage directly downstream of the VGA timing core. Consumes its pixel coordinates, draw-enable and sync outputs.
- Fetches 4-bit indexed pixels from an external synchronous framebuffer RAM, scaled down by integer power-of-two factors.
- Maps each index through a writable 16-entry palette and drives registered 6:6:6 RGB.
- Delays hsync/vsync by the same pipeline depth so colour and sync stay aligned at the connector.

Parameters:
- FB_WIDTH, 160: framebuffer pixels per row.
- X_SHIFT, 2: horizontal scale; fb_x = x >> X_SHIFT.
- Y_SHIFT, 2: vertical scale; fb_y = y >> Y_SHIFT.
- ADDR_W, 15: framebuffer address width.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_reset  in  1  synchronous, active-high reset.
- i_pixel_en  in  1  one-cycle strobe per pixel (25 MHz rate); never asserted on two consecutive i_clk cycles.
- i_x_pixel  in  10  current pixel column from the timing core.
- i_y_pixel  in  10  current pixel row from the timing core.
- i_drawing  in  1  high inside the visible area.
- i_hsync  in  1  horizontal sync from the timing core (polarity passed through).
- i_vsync  in  1  vertical sync from the timing core (polarity passed through).
- o_fb_addr  out  ADDR_W  framebuffer read address (registered).
- o_fb_rd  out  1  read request, qualifies o_fb_addr.
- i_fb_data  in  4  RAM read data, valid one i_clk after o_fb_addr changes; held while the address is stable.
- i_pal_we  in  1  palette write enable.
- i_pal_idx  in  4  palette entry to write.
- i_pal_data  in  18  palette write data, {r[5:0], g[5:0], b[5:0]}.
- o_red  out  6  red component.
- o_green  out  6  green component.
- o_blue  out  6  blue component.
- o_hsync  out  1  hsync delayed 3 strobes.
- o_vsync  out  1  vsync delayed 3 strobes.

Behaviour:
- Pipeline advances only on i_pixel_en; all stage registers hold otherwise. Palette writes are independent of i_pixel_en.
- Stage 1 (strobe N), address generation:
  - Row base register rb. When i_drawing && i_x_pixel==0:
    - if i_y_pixel==0, rb := 0;
    - else if i_y_pixel[Y_SHIFT-1:0]==0, rb := rb + FB_WIDTH;
    - else rb is unchanged.
  - o_fb_addr := rb_next + (i_x_pixel >> X_SHIFT), where rb_next is the value rb takes on this same strobe. Result is truncated to ADDR_W.
  - o_fb_rd := i_drawing.
  - No multiplier is used.
- Stage 2 (strobe N+1): latch i_fb_data into an index register, plus delayed drawing/hsync/vsync.
- Stage 3 (strobe N+2): palette lookup registered into o_red/o_green/o_blue. If the stage-3 drawing bit is 0, RGB := 0. Syncs are output from the same stage.
- Latency: exactly 3 i_pixel_en strobes from an input pixel to its colour and syncs on the outputs. Outputs are stable between strobes.
- Palette:
  - 16 x 18-bit registers.
  - Write occurs on any cycle with i_pal_we.
  - A lookup on the same cycle as a write to the same entry returns the old value. The new value is visible from the next cycle.
- Reset values:
  - Palette entry k = {g6,g6,g6} with g6 = {k, k[3:2]} (grey ramp: entry 0 = 0, entry 15 = 63 per channel).
  - rb = 0, o_fb_addr = 0, o_fb_rd = 0.
  - All pipeline valid/drawing bits = 0.
  - o_red = o_green = o_blue = 0.
  - o_hsync and o_vsync = inactive level, taken as the i_hsync/i_vsync value sampled on the first strobe after reset release.
  - Before that first strobe, both are driven 1 (active-low VGA convention).
- Reset mid-frame: the pipeline flushes, and RGB is 0 until 3 strobes after the first post-reset drawing pixel. rb resynchronises at the next y==0 line, or at the next fb row start computed from 0.
- Boundaries:
  - Row base is only updated on x==0 with drawing high, so blanking lines never advance rb.
  - The last visible line (y=479) uses rb = 119*FB_WIDTH.
  - Address overflow beyond ADDR_W wraps silently.

Test Plan:
- Reset, then strobes with drawing low -> RGB=0, o_fb_rd=0, o_hsync/o_vsync follow inputs with 3-strobe delay.
- Drawing pixel (x=0,y=0), RAM returns 4'hF -> o_fb_addr=0; strobe N+2 gives RGB=(63,63,63); index 4'h0 gives (0,0,0).
- Pixels (x=7,y=4), (x=639,y=479) -> o_fb_addr=FB_WIDTH+1=161, then 119*160+159=19199.
- y=1..3 at x=0 -> rb stays 0; y=4 -> rb=160; full frame sweep never exceeds 19199.
- Write palette idx 5 = 18'h3F000 while pixel index 5 is in stage 3 on the same cycle -> old grey {5'b0101→6'd21} shown; next lookup shows (63,0,0).
- Assert i_reset mid-line with drawing high -> next cycle RGB=0, o_fb_rd=0; first colour appears exactly 3 strobes after the first drawing strobe post-reset.

Source files
------------

// File: rtl/vga_pixel_pipeline.sv
// Three-strobe pixel pipeline after the VGA timing core: framebuffer address generation,
// indexed read capture, palette lookup to 6:6:6 RGB, with matching hsync/vsync delay.
module vga_pixel_pipeline #(
    parameter int unsigned FB_WIDTH = 160,
    parameter int unsigned X_SHIFT  = 2,
    parameter int unsigned Y_SHIFT  = 2,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pixel_en,
    input  logic [9:0]        i_x_pixel,
    input  logic [9:0]        i_y_pixel,
    input  logic              i_drawing,
    input  logic              i_hsync,
    input  logic              i_vsync,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic              o_fb_rd,
    input  logic [3:0]        i_fb_data,
    input  logic              i_pal_we,
    input  logic [3:0]        i_pal_idx,
    input  logic [17:0]       i_pal_data,
    output logic [5:0]        o_red,
    output logic [5:0]        o_green,
    output logic [5:0]        o_blue,
    output logic              o_hsync,
    output logic              o_vsync
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CH_W    = 6;
    localparam int unsigned PAL_W   = 3 * CH_W;
    localparam int unsigned PAL_N   = 16;
    localparam logic [COORD_W-1:0] Y_MASK = COORD_W'((1 << Y_SHIFT) - 1);

    function automatic logic [PAL_W-1:0] grey_entry(input logic [IDX_W-1:0] k);
        logic [CH_W-1:0] g;
        g = {k, k[3:2]};
        return {g, g, g};
    endfunction

    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rb_next;
    logic [ADDR_W-1:0] addr_next;

    logic [IDX_W-1:0]  idx_s2;
    logic              draw_s2;
    logic              hs_s1, vs_s1, hs_s2, vs_s2;
    logic              sync_primed;
    logic [PAL_W-1:0]  pal [PAL_N];

    // Row base advances by one framebuffer row at the first line of each scaled row.
    always_comb begin
        rb_next = rb;
        if (i_drawing && (i_x_pixel == '0)) begin
            if (i_y_pixel == '0) begin
                rb_next = '0;
            end else if ((i_y_pixel & Y_MASK) == '0) begin
                rb_next = rb + ADDR_W'(FB_WIDTH);
            end
        end
        addr_next = rb_next + ADDR_W'(i_x_pixel >> X_SHIFT);
    end

    // Stage 1: address generation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rb        <= '0;
            o_fb_addr <= '0;
            o_fb_rd   <= 1'b0;
        end else if (i_pixel_en) begin
            rb        <= rb_next;
            o_fb_addr <= addr_next;
            o_fb_rd   <= i_drawing;
        end
    end

    // Stages 2 and 3: index capture and palette lookup.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_s2  <= '0;
            draw_s2 <= 1'b0;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else if (i_pixel_en) begin
            idx_s2  <= i_fb_data;
            draw_s2 <= o_fb_rd;
            if (draw_s2) begin
                {o_red, o_green, o_blue} <= pal[idx_s2];
            end else begin
                {o_red, o_green, o_blue} <= '0;
            end
        end
    end

    // Sync delay line; the first strobe after reset fills it with the sampled inactive level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hs_s1       <= 1'b1;
            vs_s1       <= 1'b1;
            hs_s2       <= 1'b1;
            vs_s2       <= 1'b1;
            o_hsync     <= 1'b1;
            o_vsync     <= 1'b1;
            sync_primed <= 1'b0;
        end else if (i_pixel_en) begin
            sync_primed <= 1'b1;
            hs_s1       <= i_hsync;
            vs_s1       <= i_vsync;
            if (!sync_primed) begin
                hs_s2   <= i_hsync;
                vs_s2   <= i_vsync;
                o_hsync <= i_hsync;
                o_vsync <= i_vsync;
            end else begin
                hs_s2   <= hs_s1;
                vs_s2   <= vs_s1;
                o_hsync <= hs_s2;
                o_vsync <= vs_s2;
            end
        end
    end

    // Palette registers; a same-cycle lookup sees the pre-write value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < PAL_N; k++) begin
                pal[IDX_W'(k)] <= grey_entry(IDX_W'(k));
            end
        end else if (i_pal_we) begin
            pal[i_pal_idx] <= i_pal_data;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Scoreboard bench for vga_pixel_pipeline: stimulus pushes expected address and colour/sync
// results keyed by strobe number; a monitor pops and compares after every strobe.
module tb_vga_pixel_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_en;
    logic [9:0]  x_pixel, y_pixel;
    logic        drawing, hsync, vsync;
    logic [14:0] fb_addr;
    logic        fb_rd;
    logic [3:0]  fb_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [17:0] pal_data;
    logic [5:0]  red, green, blue;
    logic        o_hs, o_vs;

    vga_pixel_pipeline dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_pixel_en (pixel_en),
        .i_x_pixel  (x_pixel),
        .i_y_pixel  (y_pixel),
        .i_drawing  (drawing),
        .i_hsync    (hsync),
        .i_vsync    (vsync),
        .o_fb_addr  (fb_addr),
        .o_fb_rd    (fb_rd),
        .i_fb_data  (fb_data),
        .i_pal_we   (pal_we),
        .i_pal_idx  (pal_idx),
        .i_pal_data (pal_data),
        .o_red      (red),
        .o_green    (green),
        .o_blue     (blue),
        .o_hsync    (o_hs),
        .o_vsync    (o_vs)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [0:32767];
    always @(posedge clk) fb_data <= mem[fb_addr];

    typedef struct {
        int          due;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t addr_q[$];
    exp_t out_q[$];
    int   scnt    = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   primed   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [17:0] grey(input logic [3:0] k);
        logic [5:0] g;
        g = 6'(k * 4 + (k >> 2));
        return {g, g, g};
    endfunction

    // Monitor: after each accepted strobe, compare everything due on that strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pixel_en && !reset) begin
                #1;
                scnt++;
                while (addr_q.size() > 0 && addr_q[0].due == scnt) begin
                    e = addr_q.pop_front();
                    chk(e.name, {16'h0, fb_rd, fb_addr}, e.val);
                end
                while (out_q.size() > 0 && out_q[0].due == scnt) begin
                    e = out_q.pop_front();
                    chk(e.name, {12'h0, o_hs, o_vs, red, green, blue}, e.val);
                end
            end
        end
    end

    task automatic push(input bit to_out, input int due, input logic [31:0] val, input string nm);
        exp_t e;
        e.due = due; e.val = val; e.name = nm;
        if (to_out) out_q.push_back(e);
        else        addr_q.push_back(e);
    endtask

    task automatic strobe(input int x, input int y, input bit draw, input bit hs, input bit vs,
                          input logic [14:0] eaddr, input logic [17:0] ergb, input string nm,
                          input bit pw = 1'b0, input logic [3:0] pidx = 4'h0,
                          input logic [17:0] pdat = 18'h0);
        int n;
        @(negedge clk);
        n        = scnt + 1;
        x_pixel  = 10'(x);
        y_pixel  = 10'(y);
        drawing  = draw;
        hsync    = hs;
        vsync    = vs;
        pixel_en = 1'b1;
        pal_we   = pw;
        pal_idx  = pidx;
        pal_data = pdat;
        push(1'b0, n, {16'h0, draw, eaddr}, {nm, "_addr"});
        if (!primed) begin
            push(1'b1, n,     {12'h0, hs, vs, 18'h0}, {nm, "_prime0"});
            push(1'b1, n + 1, {12'h0, hs, vs, 18'h0}, {nm, "_prime1"});
            primed = 1'b1;
        end
        push(1'b1, n + 2, {12'h0, hs, vs, draw ? ergb : 18'h0}, {nm, "_out"});
        @(negedge clk);
        pixel_en = 1'b0;
        pal_we   = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset    = 1'b1;
        pixel_en = 1'b0;
        addr_q.delete();
        out_q.delete();
        @(posedge clk);
        #1;
        chk({nm, "_rgb"},   {14'h0, red, green, blue}, 32'h0);
        chk({nm, "_rd"},    {31'h0, fb_rd}, 32'h0);
        chk({nm, "_addr"},  {17'h0, fb_addr}, 32'h0);
        chk({nm, "_syncs"}, {30'h0, o_hs, o_vs}, 32'h3);
        @(negedge clk);
        reset  = 1'b0;
        primed = 1'b0;
    endtask

    initial begin
        logic [14:0] a;
        for (int i = 0; i < 32768; i++) begin
            a = 15'(i);
            mem[i] = a[3:0];
        end
        mem[0] = 4'hF;
        mem[1] = 4'h0;
        reset = 1'b1; pixel_en = 1'b0; x_pixel = '0; y_pixel = '0;
        drawing = 1'b0; hsync = 1'b1; vsync = 1'b1;
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;
        repeat (2) @(posedge clk);
        do_reset("por");

        // Blanking strobes: no reads, RGB 0, syncs delayed three strobes.
        strobe(8,  300, 0, 1, 1, 15'd2, 18'h0, "blank0");
        strobe(12, 300, 0, 0, 1, 15'd3, 18'h0, "blank1");
        strobe(0,  300, 0, 0, 0, 15'd0, 18'h0, "blank2");
        strobe(4,  300, 0, 1, 0, 15'd1, 18'h0, "blank3");

        // First rows: row base holds for y=1..3, steps at y=4.
        strobe(0, 0, 1, 1, 1, 15'd0,   18'h3FFFF, "px_0_0");
        strobe(4, 0, 1, 1, 1, 15'd1,   18'h00000, "px_4_0");
        strobe(0, 1, 1, 1, 1, 15'd0,   18'h3FFFF, "px_0_1");
        strobe(0, 2, 1, 1, 1, 15'd0,   18'h3FFFF, "px_0_2");
        strobe(0, 3, 1, 1, 1, 15'd0,   18'h3FFFF, "px_0_3");
        strobe(0, 4, 1, 1, 1, 15'd160, 18'h00000, "px_0_4");
        strobe(7, 4, 1, 1, 1, 15'd161, 18'h04104, "px_7_4");

        // Remaining visible lines at x=0, then the last pixel of the frame.
        for (int y = 5; y < 480; y++) begin
            a = 15'((y / 4) * 160);
            strobe(0, y, 1, 1, 1, a, grey(mem[a]), "sweep");
        end
        strobe(639, 479, 1, 0, 1, 15'd19199, 18'h3FFFF, "px_last");
        strobe(0, 480, 0, 1, 0, 15'd19040, 18'h0, "vblank0");
        strobe(0, 500, 0, 1, 0, 15'd19040, 18'h0, "vblank1");
        strobe(0, 0,   1, 1, 1, 15'd0, 18'h3FFFF, "frame2");

        // Palette write colliding with the lookup of index 5.
        strobe(20, 0, 1, 1, 1, 15'd5, grey(4'd5), "pal_old");
        strobe(20, 0, 1, 1, 1, 15'd5, 18'h3F000,  "pal_new");
        strobe(24, 0, 1, 1, 1, 15'd6, grey(4'd6), "pal_wr", 1'b1, 4'd5, 18'h3F000);
        strobe(28, 0, 1, 1, 1, 15'd7, grey(4'd7), "pal_after");

        // Mid-line reset with colour on the outputs and rb at 160.
        strobe(0, 4, 1, 1, 1, 15'd160, 18'h0,       "pre_rst0");
        strobe(4, 4, 1, 1, 1, 15'd161, grey(4'd1),  "pre_rst1");
        drawing = 1'b1;
        do_reset("mid_rst");
        strobe(0,  1, 0, 0, 1, 15'd0, 18'h0,      "post0");
        strobe(0,  1, 1, 1, 1, 15'd0, 18'h3FFFF,  "post1");
        strobe(20, 1, 1, 1, 0, 15'd5, grey(4'd5), "post2");
        strobe(4,  1, 1, 0, 0, 15'd1, 18'h0,      "post3");
        strobe(8,  1, 0, 1, 1, 15'd2, 18'h0,      "post4");
        strobe(8,  1, 0, 1, 1, 15'd2, 18'h0,      "post5");

        // Let the last pushed results come due, then confirm nothing is left.
        chk("pending_out_before_drain", 32'(out_q.size()), 32'd2);
        strobe(8, 1, 0, 1, 1, 15'd2, 18'h0, "drain0");
        strobe(8, 1, 0, 1, 1, 15'd2, 18'h0, "drain1");
        addr_q.delete();
        chk("pending_out_after_drain", 32'(out_q.size()), 32'd2);
        out_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
